// File: rtl/row_mem_pingpong.sv
// row_mem_pingpong
// Double-buffered row memory between the tile loader and one PE row-memory
// port. The loader streams a row into the write bank while the PE reads the
// other bank. The roles swap when a row completes and when the PE releases it.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears all control state
//   flush          synchronous clear of all control state, same as reset
//   wr_valid       loader beat valid
//   wr_ready       write bank is accepting beats (~full[wb])
//   wr_data        element to store
//   wr_last        final element of the current row
//   rd_en          PE read request
//   rd_addr        PE read address within the current read bank
//   rd_data        registered read data, one cycle after rd_en
//   rd_data_valid  rd_data holds the result of a served read
//   row_ready      read bank is full; the PE may read it
//   row_len        element count of the read bank (0 when not ready)
//   row_release    PE is finished with the read bank ("release" is a
//                  reserved word, hence the prefix)
//   banks_full     number of full banks, 0..2
//   rd_err         sticky: rd_en seen while row_ready=0
module row_mem_pingpong #(
  parameter int DATA_BW = 8,
  parameter int ADDR_W  = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [DATA_BW-1:0] wr_data,
  input  logic                      wr_last,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic signed [DATA_BW-1:0] rd_data,
  output logic                      rd_data_valid,
  output logic                      row_ready,
  output logic [ADDR_W:0]           row_len,
  input  logic                      row_release,
  output logic [1:0]                banks_full,
  output logic                      rd_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DATA_BW-1:0] mem0_r [DEPTH];
  logic [DATA_BW-1:0] mem1_r [DEPTH];

  logic               wb_r;
  logic               rb_r;
  logic [ADDR_W:0]    wr_cnt_r;
  logic [1:0]         full_r;
  logic [ADDR_W:0]    len0_r;
  logic [ADDR_W:0]    len1_r;
  logic [DATA_BW-1:0] rd_data_r;
  logic               rd_data_valid_r;
  logic               rd_err_r;

  logic               wr_fire_s;
  logic               wr_done_s;
  logic               rd_fire_s;
  logic               rel_fire_s;
  logic [ADDR_W:0]    rd_len_s;
  logic [DATA_BW-1:0] rd_mem_s;
  logic [1:0]         full_n_s;

  // Handshake qualification, read-bank selection and next full flags.
  always_comb begin
    wr_fire_s  = 1'b0;
    wr_done_s  = 1'b0;
    rd_fire_s  = 1'b0;
    rel_fire_s = 1'b0;
    rd_len_s   = len0_r;
    rd_mem_s   = mem0_r[rd_addr];
    full_n_s   = full_r;

    wr_fire_s  = wr_valid & ~full_r[wb_r];
    // A row completes on wr_last or when the bank is about to overflow.
    wr_done_s  = wr_fire_s & (wr_last | (wr_cnt_r == CNT_MAX));
    rd_fire_s  = rd_en & full_r[rb_r];
    rel_fire_s = row_release & full_r[rb_r];

    if (rb_r) begin
      rd_len_s = len1_r;
      rd_mem_s = mem1_r[rd_addr];
    end else begin
      rd_len_s = len0_r;
      rd_mem_s = mem0_r[rd_addr];
    end

    // Completion is applied after release so it wins on the same bank.
    if (rel_fire_s) begin
      full_n_s[rb_r] = 1'b0;
    end else begin
      full_n_s = full_n_s;
    end
    if (wr_done_s) begin
      full_n_s[wb_r] = 1'b1;
    end else begin
      full_n_s = full_n_s;
    end
  end

  // Bank storage: write port only, contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !wb_r) begin
      mem0_r[wr_cnt_r[ADDR_W-1:0]] <= wr_data;
    end
    if (wr_fire_s && wb_r) begin
      mem1_r[wr_cnt_r[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Control state and registered read port.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wb_r            <= 1'b0;
      rb_r            <= 1'b0;
      wr_cnt_r        <= {(ADDR_W + 1){1'b0}};
      full_r          <= 2'b00;
      len0_r          <= {(ADDR_W + 1){1'b0}};
      len1_r          <= {(ADDR_W + 1){1'b0}};
      rd_data_r       <= {DATA_BW{1'b0}};
      rd_data_valid_r <= 1'b0;
      rd_err_r        <= 1'b0;
    end else begin
      full_r <= full_n_s;

      if (wr_done_s) begin
        wb_r     <= ~wb_r;
        wr_cnt_r <= {(ADDR_W + 1){1'b0}};
        if (wb_r) begin
          len1_r <= wr_cnt_r + CNT_ONE;
        end else begin
          len0_r <= wr_cnt_r + CNT_ONE;
        end
      end else if (wr_fire_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_ONE;
      end

      // The read in a release cycle already used the pre-toggle rb.
      if (rel_fire_s) begin
        rb_r <= ~rb_r;
      end

      if (rd_fire_s) begin
        rd_data_valid_r <= 1'b1;
        if ({1'b0, rd_addr} >= rd_len_s) begin
          rd_data_r <= {DATA_BW{1'b0}};
        end else begin
          rd_data_r <= rd_mem_s;
        end
      end else begin
        rd_data_valid_r <= 1'b0;
        if (rd_en) begin
          rd_err_r <= 1'b1;
        end
      end
    end
  end

  assign wr_ready      = ~full_r[wb_r];
  assign row_ready     = full_r[rb_r];
  assign row_len       = full_r[rb_r] ? rd_len_s : {(ADDR_W + 1){1'b0}};
  assign banks_full    = {1'b0, full_r[0]} + {1'b0, full_r[1]};
  assign rd_data       = rd_data_r;
  assign rd_data_valid = rd_data_valid_r;
  assign rd_err        = rd_err_r;

endmodule
